// File: rtl/arbitro_soc_eoc_if.sv
// Handshake bus between the two-requester arbiter, its requesters and the shared producer.
interface arbitro_soc_eoc_if #(parameter int W = 8);
   logic         req0;
   logic         req1;
   logic         ack0;
   logic         ack1;
   logic [W-1:0] dato;
   logic         soc;
   logic         eoc;
   logic [W-1:0] numero;
   logic         err;

   modport slave (
      input  req0, req1, eoc, numero,
      output ack0, ack1, dato, soc, err
   );

   modport master (
      output req0, req1, eoc, numero,
      input  ack0, ack1, dato, soc, err
   );
endinterface

// File: rtl/arbitro_soc_eoc.sv
// Round-robin arbiter granting two four-phase requesters access to one soc/eoc producer.
// Optional watchdog abort of stalled producer cycles is enabled by defining ARB_TIMEOUT_EN.
module arbitro_soc_eoc #(
   parameter int W   = 8,
   parameter int TMO = 200
) (
   input  logic              clock,
   input  logic              reset_,
   arbitro_soc_eoc_if.slave  bus
);

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_t;

   state_t         r_star;
   logic           r_gnt;
   logic           r_last;
   logic           r_soc;
   logic           r_ack0;
   logic           r_ack1;
   logic           r_err;
   logic [W-1:0]   r_dato;

   logic           w_any;
   logic           w_win;
   logic           w_req_gnt;
   logic           w_tmo;

   assign w_any     = bus.req0 | bus.req1;
   // On a tie the requester that was not served last wins.
   assign w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
   assign w_req_gnt = r_gnt ? bus.req1 : bus.req0;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0]  r_cnt;

   // The abort fires on the edge that would bring the counter to TMO.
   assign w_tmo = ((r_star == S1) || (r_star == S2)) && (r_cnt == CW'(TMO - 1));

   // Watchdog counter: cleared while idle, counts every edge spent waiting on the producer.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_cnt <= '0;
      end else if (r_star == S0) begin
         r_cnt <= '0;
      end else if ((r_star == S1) || (r_star == S2)) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= r_cnt;
      end
   end
`else
   wire [31:0] w_unused_tmo = 32'(TMO);

   assign w_tmo = 1'b0;
`endif

   // Arbitration and producer handshake state machine with registered outputs.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_star <= S0;
         r_gnt  <= 1'b0;
         r_last <= 1'b1;
         r_soc  <= 1'b0;
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err  <= 1'b0;
         r_dato <= '0;
      end else begin
         case (r_star)
            S0: begin
               if (w_any) begin
                  r_gnt  <= w_win;
                  r_soc  <= 1'b1;
                  r_star <= S1;
               end else begin
                  r_soc  <= 1'b0;
               end
            end
            S1: begin
               if (w_tmo) begin
                  r_soc  <= 1'b0;
                  r_err  <= 1'b1;
                  if (r_gnt) r_ack1 <= 1'b1;
                  else       r_ack0 <= 1'b1;
                  r_star <= S3;
               end else if (!bus.eoc) begin
                  r_soc  <= 1'b0;
                  r_star <= S2;
               end
            end
            S2: begin
               if (w_tmo) begin
                  r_soc  <= 1'b0;
                  r_err  <= 1'b1;
                  if (r_gnt) r_ack1 <= 1'b1;
                  else       r_ack0 <= 1'b1;
                  r_star <= S3;
               end else if (bus.eoc) begin
                  r_dato <= bus.numero;
                  if (r_gnt) r_ack1 <= 1'b1;
                  else       r_ack0 <= 1'b1;
                  r_star <= S3;
               end
            end
            S3: begin
               // A request dropped early still lands here and leaves after one edge.
               if (!w_req_gnt) begin
                  r_ack0 <= 1'b0;
                  r_ack1 <= 1'b0;
                  r_err  <= 1'b0;
                  r_last <= r_gnt;
                  r_star <= S0;
               end
            end
            default: begin
               r_star <= S0;
            end
         endcase
      end
   end

   assign bus.ack0 = r_ack0;
   assign bus.ack1 = r_ack1;
   assign bus.soc  = r_soc;
   assign bus.err  = r_err;
   assign bus.dato = r_dato;

endmodule

// File: doc/arbitro_soc_eoc.md
ARBITRO_SOC_EOC -- requirements
Module: arbitro_soc_eoc

Interface
REQ-001 Parameter: W, 8, width of the data word returned by the shared producer.
REQ-002 Parameter: TMO, 200, watchdog limit in clock cycles (used only when ARB_TIMEOUT_EN is defined).
REQ-003 Port: clock  input  1  single clock; all registered state updates on posedge.
REQ-004 Port: reset_  input  1  asynchronous, active-low reset.
REQ-005 Port: req0, req1  input  1 each  four-phase request from requester 0 / 1.
REQ-006 Port: ack0, ack1  output  1 each  four-phase acknowledge to requester 0 / 1.
REQ-007 Port: dato  output  W  last word fetched; valid while the corresponding ack is 1.
REQ-008 Port: soc  output  1  start-of-conversion to the shared producer.
REQ-009 Port: eoc  input  1  end-of-conversion from the producer; 1 when the producer is idle.
REQ-010 Port: numero  input  W  producer data; stable while eoc is 1.
REQ-011 Port: err  output  1  watchdog abort flag for the current transaction.

Function
REQ-012 All outputs SHALL be driven directly from registers; no combinational input-to-output path.
REQ-013 The FSM SHALL have four states: S0 idle, S1 wait eoc=0, S2 wait eoc=1, S3 wait req release.
REQ-014 S0: if req0|req1, latch the winner into GNT, set soc=1, go to S1; otherwise stay in S0 with soc=0.
REQ-015 Winner selection SHALL be round-robin: if only one req is high, it wins; if both are high, the requester not equal to LAST wins.
REQ-016 S1: stay while eoc=1; when eoc=0, set soc=0 and go to S2.
REQ-017 S2: stay while eoc=0; when eoc=1, load dato<=numero, set ack[GNT]=1, go to S3.
REQ-018 S3: stay while req[GNT]=1; when req[GNT]=0, clear ack[GNT] and err, set LAST<=GNT, go to S0.
REQ-019 At most one ack SHALL be high at any time; the ack of the non-granted requester SHALL stay 0.
REQ-020 Minimum transaction SHALL take 4 clock edges from grant to return to S0: grant, eoc low, eoc high, release.
REQ-021 A req of the non-granted requester raised mid-transaction SHALL be held off until S0 and SHALL win the next arbitration.
REQ-022 A req[GNT] dropped before ack (protocol violation) SHALL NOT abort the producer cycle; S3 then exits on the next edge (1-cycle ack pulse).
REQ-023 dato SHALL hold its value between transactions; it changes only in S2 on the eoc=1 edge.

Reset
REQ-024 With reset_=0, asynchronously: STAR=S0, soc=0, ack0=ack1=0, dato=0, err=0, GNT=0, LAST=1, watchdog counter=0.
REQ-025 Reset asserted mid-transaction SHALL abandon it immediately; the producer is not signalled further; after reset, arbitration restarts in S0 with requester 0 winning a tie.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN: when defined, a counter SHALL clear on entry to S1 and increment on each edge spent in S1 or S2.
REQ-027 With ARB_TIMEOUT_EN defined, when the counter reaches TMO: soc<=0, err<=1, dato unchanged, ack[GNT]<=1, go to S3 (requester releases normally).
REQ-028 Without ARB_TIMEOUT_EN: no counter is built, err SHALL be constant 0, and S1/S2 wait indefinitely.

Verification
REQ-029 req0=1 alone, producer drops eoc after 2 cycles and raises it with numero=0x5A after 3 more -> soc high exactly from grant to eoc=0, ack0=1 with dato=0x5A, ack1=0 throughout.
REQ-030 req0 and req1 raised on the same edge after reset -> requester 0 served first; after its release requester 1 is served without a new req edge; tie repeated afterwards -> requester 0 wins again (LAST=1).
REQ-031 req1 raised while requester 0 is in S2 -> ack1 stays 0 until ack0 falls; requester 1 is granted on the next edge in S0.
REQ-032 reset_ pulsed low while in S2 -> soc=0, ack0=ack1=0, dato=0 immediately without a clock edge; a new req completes normally afterwards.
REQ-033 ARB_TIMEOUT_EN defined, TMO=10, eoc held at 1 forever after grant -> after 10 cycles soc=0, err=1, ack0=1, dato unchanged; req0 released -> err=0, ack0=0, STAR=S0.
REQ-034 Same stimulus without ARB_TIMEOUT_EN -> soc stays 1, err stays 0, no ack for 1000 cycles.
